// File: rtl/micro_sequencer_if.sv
// Control bundle between micro_sequencer and the datapath: instruction/status in, control lines out.
interface micro_sequencer_if #(
  parameter int ALU_OP_W = 5
);
  logic [31:0]         IR;
  logic                CON;
  logic                MemReady;
  logic [9:0]          reg_in;
  logic [7:0]          bus_out;
  logic [5:0]          gsel;
  logic                Read;
  logic                Write;
  logic                IncPC;
  logic [ALU_OP_W-1:0] alu_op;

  modport master (
    input  IR, CON, MemReady,
    output reg_in, bus_out, gsel, Read, Write, IncPC, alu_op
  );

  modport slave (
    output IR, CON, MemReady,
    input  reg_in, bus_out, gsel, Read, Write, IncPC, alu_op
  );
endinterface

// File: rtl/micro_sequencer.sv
// Hardwired fetch/decode/execute sequencer: a Moore FSM stepping T0..T7 per instruction,
// with memory-wait handshaking, timeout fault and run/halt control.
module micro_sequencer #(
  parameter int OPC_W       = 5,
  parameter int ALU_OP_W    = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Run,
  micro_sequencer_if.master dp,
  output logic [3:0]        step,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_IDLE = 4'd8, S_HALT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_MULDIV, C_IMM, C_LD, C_ST, C_BR, C_OUT, C_IN, C_HALT
  } iclass_t;

  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(5'b00000);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(5'b00010);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(5'b01011);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'b01100);
  localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(5'b01101);
  localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(5'b01110);
  localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(5'b01111);
  localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(5'b10000);
  localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(5'b10011);
  localparam logic [OPC_W-1:0] OP_IN   = OPC_W'(5'b10110);
  localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'(5'b10111);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11011);

  localparam logic [ALU_OP_W-1:0] ALU_ADD      = ALU_OP_W'(5'b00011);
  localparam logic [7:0]          TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  // reg_in / bus_out / gsel bit positions
  localparam int HI_IN = 0, LO_IN = 1, PC_IN = 2, MDR_IN = 3, Z_IN = 4;
  localparam int Y_IN = 5, MAR_IN = 6, IR_IN = 7, CON_IN = 8, OUTP_IN = 9;
  localparam int HI_O = 0, LO_O = 1, ZHI_O = 2, ZLO_O = 3, PC_O = 4;
  localparam int MDR_O = 5, INP_O = 6, C_O = 7;
  localparam int GRA = 0, GRB = 1, GRC = 2, RIN = 3, ROUT = 4, BAOUT = 5;

  state_t              state, state_nx, adv;
  iclass_t             iclass;
  logic [7:0]          wait_cnt, wait_cnt_nx;
  logic                fault_q, fault_nx;
  logic                done, mem_wait;
  logic [OPC_W-1:0]    opc;
  logic [9:0]          reg_in;
  logic [7:0]          bus_out;
  logic [5:0]          gsel;
  logic                rd, wr, inc_pc;
  logic [ALU_OP_W-1:0] alu_op;
  logic                unused_ir_bits;

  assign opc            = dp.IR[31 -: OPC_W];
  assign unused_ir_bits = ^dp.IR[31-OPC_W:0];

  always_comb begin
    if (opc inside {[OP_ADD:OP_SHL]})               iclass = C_ALU;
    else if (opc == OP_MUL || opc == OP_DIV)        iclass = C_MULDIV;
    else if (opc inside {OP_ADDI, OP_ANDI, OP_ORI}) iclass = C_IMM;
    else if (opc == OP_LD)                          iclass = C_LD;
    else if (opc == OP_ST)                          iclass = C_ST;
    else if (opc == OP_BR)                          iclass = C_BR;
    else if (opc == OP_OUT)                         iclass = C_OUT;
    else if (opc == OP_IN)                          iclass = C_IN;
    else if (opc == OP_HALT)                        iclass = C_HALT;
    else                                            iclass = C_NOP;
  end

  // nop and halt resolve at the end of T2, so the opcode must already be visible on IR there.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    adv      = state;
    done     = 1'b0;
    mem_wait = 1'b0;
    case (state)
      S_IDLE: adv = Run ? S_T0 : S_IDLE;
      S_T0:   adv = S_T1;
      S_T1:   begin mem_wait = 1'b1; adv = S_T2; end
      S_T2: begin
        if (iclass == C_NOP)       done = 1'b1;
        else if (iclass == C_HALT) adv  = S_HALT;
        else                       adv  = S_T3;
      end
      S_T3: if (iclass inside {C_OUT, C_IN}) done = 1'b1; else adv = S_T4;
      S_T4: adv = S_T5;
      S_T5: if (iclass inside {C_ALU, C_IMM}) done = 1'b1; else adv = S_T6;
      S_T6: begin
        if (iclass == C_LD)      begin mem_wait = 1'b1; adv = S_T7; end
        else if (iclass == C_ST) adv = S_T7;
        else                     done = 1'b1;
      end
      S_T7: begin mem_wait = (iclass == C_ST); done = 1'b1; end
      S_HALT: adv = S_HALT;
      default: adv = S_IDLE;
    endcase
    if (done) adv = Run ? S_T0 : S_IDLE;

    // The wait counter is cleared whenever the state changes, i.e. on entry to any wait state.
    state_nx    = adv;
    wait_cnt_nx = '0;
    fault_nx    = fault_q;
    if (mem_wait && !dp.MemReady) begin
      if (wait_cnt == TIMEOUT_LAST) begin
        state_nx = S_HALT;
        fault_nx = 1'b1;
      end else begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Clear) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      fault_q  <= fault_nx;
    end
  end

  // Controls decode from the state register plus the live IR/CON, so Clear zeroes them at once.
  always_comb begin
    reg_in  = '0;
    bus_out = '0;
    gsel    = '0;
    rd      = 1'b0;
    wr      = 1'b0;
    inc_pc  = 1'b0;
    alu_op  = '0;
    case (state)
      S_T0: begin
        bus_out[PC_O] = 1'b1; reg_in[MAR_IN] = 1'b1; reg_in[Z_IN] = 1'b1;
        inc_pc = 1'b1; alu_op = ALU_ADD;
      end
      S_T1: begin
        bus_out[ZLO_O] = 1'b1; reg_in[PC_IN] = 1'b1; reg_in[MDR_IN] = 1'b1; rd = 1'b1;
      end
      S_T2: begin bus_out[MDR_O] = 1'b1; reg_in[IR_IN] = 1'b1; end
      S_T3: begin
        case (iclass)
          C_ALU, C_MULDIV, C_IMM: begin gsel[GRB] = 1'b1; gsel[ROUT] = 1'b1; reg_in[Y_IN] = 1'b1; end
          C_LD, C_ST:             begin gsel[GRB] = 1'b1; gsel[BAOUT] = 1'b1; reg_in[Y_IN] = 1'b1; end
          C_BR:  begin gsel[GRA] = 1'b1; gsel[ROUT] = 1'b1; reg_in[CON_IN] = 1'b1; end
          C_OUT: begin gsel[GRA] = 1'b1; gsel[ROUT] = 1'b1; reg_in[OUTP_IN] = 1'b1; end
          C_IN:  begin bus_out[INP_O] = 1'b1; gsel[GRA] = 1'b1; gsel[RIN] = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (iclass)
          C_ALU, C_MULDIV: begin
            gsel[GRC] = 1'b1; gsel[ROUT] = 1'b1; reg_in[Z_IN] = 1'b1; alu_op = ALU_OP_W'(opc);
          end
          C_IMM:      begin bus_out[C_O] = 1'b1; reg_in[Z_IN] = 1'b1; alu_op = ALU_OP_W'(opc); end
          C_LD, C_ST: begin bus_out[C_O] = 1'b1; reg_in[Z_IN] = 1'b1; alu_op = ALU_ADD; end
          C_BR:       begin bus_out[PC_O] = 1'b1; reg_in[Y_IN] = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (iclass)
          C_ALU, C_IMM: begin bus_out[ZLO_O] = 1'b1; gsel[GRA] = 1'b1; gsel[RIN] = 1'b1; end
          C_MULDIV:     begin bus_out[ZLO_O] = 1'b1; reg_in[LO_IN] = 1'b1; end
          C_LD, C_ST:   begin bus_out[ZLO_O] = 1'b1; reg_in[MAR_IN] = 1'b1; end
          C_BR:         begin bus_out[C_O] = 1'b1; reg_in[Z_IN] = 1'b1; alu_op = ALU_ADD; end
          default: ;
        endcase
      end
      S_T6: begin
        case (iclass)
          C_MULDIV: begin bus_out[ZHI_O] = 1'b1; reg_in[HI_IN] = 1'b1; end
          C_LD:     begin rd = 1'b1; reg_in[MDR_IN] = 1'b1; end
          C_ST:     begin gsel[GRA] = 1'b1; gsel[ROUT] = 1'b1; reg_in[MDR_IN] = 1'b1; end
          C_BR: if (dp.CON) begin bus_out[ZLO_O] = 1'b1; reg_in[PC_IN] = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        if (iclass == C_LD) begin
          bus_out[MDR_O] = 1'b1; gsel[GRA] = 1'b1; gsel[RIN] = 1'b1;
        end else if (iclass == C_ST) begin
          wr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign dp.reg_in  = reg_in;
  assign dp.bus_out = bus_out;
  assign dp.gsel    = gsel;
  assign dp.Read    = rd;
  assign dp.Write   = wr;
  assign dp.IncPC   = inc_pc;
  assign dp.alu_op  = alu_op;

  assign step   = (state == S_IDLE || state == S_HALT) ? 4'd0 : 4'(state);
  assign halted = (state == S_HALT);
  assign fault  = fault_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: instruction classes, memory waits, timeout, Clear and Run control.
module tb_micro_sequencer;

  localparam logic [9:0] HI_IN = 10'h001, LO_IN = 10'h002, PC_IN = 10'h004, MDR_IN = 10'h008;
  localparam logic [9:0] Z_IN = 10'h010, Y_IN = 10'h020, MAR_IN = 10'h040, IR_IN = 10'h080;
  localparam logic [9:0] CON_IN = 10'h100, OUTP_IN = 10'h200;
  localparam logic [7:0] ZHI_O = 8'h04, ZLO_O = 8'h08, PC_O = 8'h10, MDR_O = 8'h20;
  localparam logic [7:0] INP_O = 8'h40, C_O = 8'h80;
  localparam logic [5:0] GRA = 6'h01, GRB = 6'h02, GRC = 6'h04, RIN = 6'h08, ROUT = 6'h10, BAOUT = 6'h20;

  logic       Clock = 1'b0;
  logic       Clear;
  logic       Run;
  logic [3:0] step;
  logic       halted;
  logic       fault;
  int         n_checks = 0;
  int         n_pass = 0;
  int         write_count = 0;
  int         write_base;

  micro_sequencer_if #(.ALU_OP_W(5)) dp ();

  micro_sequencer #(.OPC_W(5), .ALU_OP_W(5), .MEM_TIMEOUT(15)) dut (
    .Clock  (Clock),
    .Clear  (Clear),
    .Run    (Run),
    .dp     (dp),
    .step   (step),
    .halted (halted),
    .fault  (fault)
  );

  always #5 Clock = ~Clock;

  always @(posedge dp.Write) write_count++;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk(string tag, logic [3:0] st, logic [9:0] ri, logic [7:0] bo,
                     logic [5:0] gs, logic rd, logic wr, logic inc);
    check({tag, ".step"},    32'(step),       32'(st));
    check({tag, ".reg_in"},  32'(dp.reg_in),  32'(ri));
    check({tag, ".bus_out"}, 32'(dp.bus_out), 32'(bo));
    check({tag, ".gsel"},    32'(dp.gsel),    32'(gs));
    check({tag, ".rd_wr_inc"}, 32'({dp.Read, dp.Write, dp.IncPC}), 32'({rd, wr, inc}));
  endtask

  task automatic next_cycle();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    Clear = 1'b1; Run = 1'b0;
    dp.IR = 32'h0; dp.CON = 1'b0; dp.MemReady = 1'b1;
    repeat (2) @(negedge Clock);
    chk("reset", 4'd0, '0, '0, '0, 0, 0, 0);
    check("reset.halted", 32'(halted), 32'd0);
    check("reset.fault", 32'(fault), 32'd0);
    Clear = 1'b0;
    next_cycle();
    chk("idle", 4'd0, '0, '0, '0, 0, 0, 0);

    // andi R2,R3,7
    dp.IR = 32'h6918_0007; Run = 1'b1;
    next_cycle(); chk("andi.T0", 4'd0, MAR_IN | Z_IN, PC_O, '0, 0, 0, 1);
    next_cycle(); chk("andi.T1", 4'd1, PC_IN | MDR_IN, ZLO_O, '0, 1, 0, 0);
    next_cycle(); chk("andi.T2", 4'd2, IR_IN, MDR_O, '0, 0, 0, 0);
    next_cycle(); chk("andi.T3", 4'd3, Y_IN, '0, GRB | ROUT, 0, 0, 0);
    next_cycle(); chk("andi.T4", 4'd4, Z_IN, C_O, '0, 0, 0, 0);
    check("andi.T4.alu", 32'(dp.alu_op), 32'h0D);
    next_cycle(); chk("andi.T5", 4'd5, '0, ZLO_O, GRA | RIN, 0, 0, 0);
    next_cycle(); chk("andi.next", 4'd0, MAR_IN | Z_IN, PC_O, '0, 0, 0, 1);

    // mul: seven cycles T0..T6
    dp.IR = 32'h8000_0000;
    repeat (3) next_cycle();
    chk("mul.T3", 4'd3, Y_IN, '0, GRB | ROUT, 0, 0, 0);
    next_cycle(); chk("mul.T4", 4'd4, Z_IN, '0, GRC | ROUT, 0, 0, 0);
    check("mul.T4.alu", 32'(dp.alu_op), 32'h10);
    next_cycle(); chk("mul.T5", 4'd5, LO_IN, ZLO_O, '0, 0, 0, 0);
    next_cycle(); chk("mul.T6", 4'd6, HI_IN, ZHI_O, '0, 0, 0, 0);
    next_cycle(); chk("mul.next", 4'd0, MAR_IN | Z_IN, PC_O, '0, 0, 0, 1);

    // br with CON = 0
    dp.IR = 32'h9800_0000; dp.CON = 1'b0;
    repeat (3) next_cycle();
    chk("br0.T3", 4'd3, CON_IN, '0, GRA | ROUT, 0, 0, 0);
    next_cycle(); chk("br0.T4", 4'd4, Y_IN, PC_O, '0, 0, 0, 0);
    next_cycle(); chk("br0.T5", 4'd5, Z_IN, C_O, '0, 0, 0, 0);
    check("br0.T5.alu", 32'(dp.alu_op), 32'h03);
    next_cycle(); chk("br0.T6", 4'd6, '0, '0, '0, 0, 0, 0);
    next_cycle(); chk("br0.next", 4'd0, MAR_IN | Z_IN, PC_O, '0, 0, 0, 1);

    // br with CON = 1
    dp.CON = 1'b1;
    repeat (6) next_cycle();
    chk("br1.T6", 4'd6, PC_IN, ZLO_O, '0, 0, 0, 0);
    next_cycle(); chk("br1.next", 4'd0, MAR_IN | Z_IN, PC_O, '0, 0, 0, 1);
    dp.CON = 1'b0;

    // ld with MemReady low for three cycles of T6
    dp.IR = 32'h0000_0000;
    repeat (3) next_cycle();
    chk("ld.T3", 4'd3, Y_IN, '0, GRB | BAOUT, 0, 0, 0);
    next_cycle(); chk("ld.T4", 4'd4, Z_IN, C_O, '0, 0, 0, 0);
    check("ld.T4.alu", 32'(dp.alu_op), 32'h03);
    next_cycle(); chk("ld.T5", 4'd5, MAR_IN, ZLO_O, '0, 0, 0, 0);
    dp.MemReady = 1'b0;
    next_cycle();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ld.T6.c%0d", i), 4'd6, MDR_IN, '0, '0, 1, 0, 0);
      if (i == 4) dp.MemReady = 1'b1;
      next_cycle();
    end
    chk("ld.T7", 4'd7, '0, MDR_O, GRA | RIN, 0, 0, 0);
    next_cycle(); chk("ld.next", 4'd0, MAR_IN | Z_IN, PC_O, '0, 0, 0, 1);

    // out, with Run dropped mid-instruction: finishes, then IDLE
    dp.IR = 32'hB800_0000;
    next_cycle(); Run = 1'b0;
    next_cycle(); chk("out.T2", 4'd2, IR_IN, MDR_O, '0, 0, 0, 0);
    next_cycle(); chk("out.T3", 4'd3, OUTP_IN, '0, GRA | ROUT, 0, 0, 0);
    next_cycle(); chk("out.idle", 4'd0, '0, '0, '0, 0, 0, 0);
    next_cycle(); chk("out.idle2", 4'd0, '0, '0, '0, 0, 0, 0);

    // in
    dp.IR = 32'hB000_0000; Run = 1'b1;
    repeat (4) next_cycle();
    chk("in.T3", 4'd3, '0, INP_O, GRA | RIN, 0, 0, 0);
    next_cycle(); chk("in.next", 4'd0, MAR_IN | Z_IN, PC_O, '0, 0, 0, 1);

    // st aborted by Clear in T6
    dp.IR = 32'h1000_0000; write_base = write_count;
    repeat (6) next_cycle();
    chk("st.T6", 4'd6, MDR_IN, '0, GRA | ROUT, 0, 0, 0);
    #2 Clear = 1'b1;
    #1 chk("st.clear", 4'd0, '0, '0, '0, 0, 0, 0);
    @(negedge Clock);
    Clear = 1'b0; Run = 1'b0;
    next_cycle(); chk("st.idle", 4'd0, '0, '0, '0, 0, 0, 0);
    check("st.no_write", 32'(write_count - write_base), 32'd0);

    // MemReady never arrives in T1: fault after 15 cycles
    Run = 1'b1; dp.MemReady = 1'b0;
    next_cycle(); next_cycle();
    repeat (14) next_cycle();
    chk("to.T1.last", 4'd1, PC_IN | MDR_IN, ZLO_O, '0, 1, 0, 0);
    check("to.T1.fault", 32'(fault), 32'd0);
    next_cycle();
    chk("to.halt", 4'd0, '0, '0, '0, 0, 0, 0);
    check("to.halted", 32'({halted, fault}), 32'b11);
    dp.MemReady = 1'b1;
    repeat (3) next_cycle();
    chk("to.hold", 4'd0, '0, '0, '0, 0, 0, 0);
    check("to.hold.halted", 32'({halted, fault}), 32'b11);
    Clear = 1'b1;
    #1 check("to.clear", 32'({halted, fault}), 32'b00);

    // halt instruction
    dp.IR = 32'hD800_0000;
    @(negedge Clock); Clear = 1'b0;
    next_cycle(); chk("halt.T0", 4'd0, MAR_IN | Z_IN, PC_O, '0, 0, 0, 1);
    next_cycle(); next_cycle();
    chk("halt.T2", 4'd2, IR_IN, MDR_O, '0, 0, 0, 0);
    next_cycle();
    check("halt.halted", 32'({halted, fault}), 32'b10);
    chk("halt.out", 4'd0, '0, '0, '0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
